// File: rtl/sram_rd_ctrl_pkg.sv
// Shared types and constants for the SRAM burst read controller.
// Holds the FSM state encoding, the default address width and default access wait.
package sram_rd_ctrl_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int RD_WAIT_DEF = 2;
    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT,
        CAPT,
        HOLD,
        FIN
    } state_t;

endpackage

// File: rtl/sram_rd_obuf.sv
// Output word register with valid/ready hold for the SRAM read stream.
// Latency: data registered on load, dout_valid raised one cycle later.
// Backpressure: dout/dout_valid held stable until dout_ready; flush drops the word.
module sram_rd_obuf (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        flush,
    input  logic        load,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready
);

    logic [15:0] dat_q;
    logic        pend_q;
    logic        vld_q;

    // The pending stage adds the final cycle of read latency after the capture edge.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            dat_q  <= 16'h0000;
            pend_q <= 1'b0;
            vld_q  <= 1'b0;
        end else if (flush) begin
            pend_q <= 1'b0;
            vld_q  <= 1'b0;
        end else if (load) begin
            dat_q  <= din;
            pend_q <= 1'b1;
        end else if (pend_q) begin
            pend_q <= 1'b0;
            vld_q  <= 1'b1;
        end else if (vld_q && dout_ready) begin
            vld_q  <= 1'b0;
        end
    end

    assign dout       = dat_q;
    assign dout_valid = vld_q;

endmodule

// File: rtl/sram_rd_ctrl.sv
// Burst reader for an asynchronous 16-bit SRAM; optional checksum via SRAM_RD_CHKSUM_EN.
// Latency: first word valid RD_WAIT+3 cycles after start, then RD_WAIT+3 after each handshake.
// Backpressure: no new SRAM access is issued until the held word is accepted.
module sram_rd_ctrl
    import sram_rd_ctrl_pkg::*;
#(
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int ADDR_W  = SRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              nRESET,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_cnt,
    input  logic [15:0]       SRAM_DATA,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_nCS,
    output logic              SRAM_nOE,
    output logic              SRAM_nWE,
    output logic [15:0]       dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
`ifdef SRAM_RD_CHKSUM_EN
    ,
    output logic [15:0]       chksum
`endif
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(RD_WAIT - 1);

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W-1:0]       rem_q, rem_d;
    logic [WAIT_CNT_W-1:0]   wait_q, wait_d;
    logic                    hs;
    logic                    strobe;
    logic                    cap;

    assign hs = dout_valid & dout_ready;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_cnt != '0) begin
                        state_d = SETUP;
                        addr_d  = base_addr;
                        rem_d   = word_cnt;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            SETUP: begin
                state_d = WAIT;
                wait_d  = '0;
            end
            WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = CAPT;
                    wait_d  = '0;
                end else begin
                    wait_d  = wait_q + 1'b1;
                end
            end
            // Address advances once the word is captured; it wraps at the width naturally.
            CAPT: begin
                state_d = HOLD;
                addr_d  = addr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
            end
            HOLD: begin
                if (hs) begin
                    state_d = (rem_q == '0) ? FIN : SETUP;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            rem_d   = '0;
            wait_d  = '0;
        end
    end

    assign strobe    = (state_q == SETUP) || (state_q == WAIT) || (state_q == CAPT);
    assign SRAM_nCS  = ~strobe;
    assign SRAM_nOE  = ~strobe;
    assign SRAM_nWE  = 1'b1;
    assign SRAM_ADDR = addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign cap       = (state_q == CAPT) && !abort;

    sram_rd_obuf u_obuf (
        .clk        (clk),
        .nRESET     (nRESET),
        .flush      (abort),
        .load       (cap),
        .din        (SRAM_DATA),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

`ifdef SRAM_RD_CHKSUM_EN
    logic [15:0] chk_q;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            chk_q <= 16'h0000;
        end else if ((state_q == IDLE) && start && !abort) begin
            chk_q <= 16'h0000;
        end else if (hs) begin
            chk_q <= chk_q + dout;
        end
    end

    assign chksum = chk_q;
`endif

endmodule

// File: doc/sram_rd_ctrl.md
SRAM_RD_CTRL -- requirements
Module: sram_rd_ctrl

Interface
REQ-001 SHALL have parameter RD_WAIT, default 2, the number of SRAM access wait cycles (1..15).
REQ-002 SHALL have parameter ADDR_W, default 18, the SRAM word-address width.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port nRESET, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to begin a burst read.
REQ-006 SHALL have port abort, input, 1, cancels any burst in progress.
REQ-007 SHALL have port base_addr, input, ADDR_W, the first word address.
REQ-008 SHALL have port word_cnt, input, ADDR_W, the number of words to read.
REQ-009 SHALL have port SRAM_DATA, input, 16, the SRAM read data.
REQ-010 SHALL have ports SRAM_ADDR (output, ADDR_W) and SRAM_nCS, SRAM_nOE, SRAM_nWE (each output, 1, active-low).
REQ-011 SHALL have ports dout (output, 16), dout_valid (output, 1) and dout_ready (input, 1), a consumer valid/ready stream.
REQ-012 SHALL have ports busy (output, 1) and done (output, 1, one-cycle pulse).

Function
REQ-013 SHALL implement states IDLE, SETUP, WAIT, CAPT, HOLD, FIN.
- IDLE: start=1 with word_cnt>0 -> SETUP, latching base_addr and word_cnt.
- IDLE: start=1 with word_cnt==0 -> FIN.
- SETUP: drive SRAM_ADDR, assert SRAM_nCS=0 and SRAM_nOE=0 -> WAIT.
- WAIT: count RD_WAIT cycles -> CAPT.
- CAPT: register SRAM_DATA into dout -> HOLD.
- HOLD: on dout_valid&dout_ready, go to SETUP if words remain, else FIN.
- FIN: done=1 for one cycle -> IDLE.
REQ-014 SHALL raise the first dout_valid exactly RD_WAIT+3 cycles after the clock edge that samples start; each subsequent dout_valid SHALL rise RD_WAIT+3 cycles after the previous handshake edge.
REQ-015 SHALL hold dout and dout_valid stable while dout_valid=1 and dout_ready=0, and SHALL deassert dout_valid the cycle after a handshake.
REQ-016 SHALL keep SRAM_nWE=1 at all times; SRAM_nCS and SRAM_nOE SHALL be 0 only in SETUP, WAIT and CAPT.
REQ-017 SHALL increment the address by 1 per word modulo 2^ADDR_W, so that address 2^ADDR_W-1 wraps to 0.
REQ-018 SHALL ignore start while busy=1; busy SHALL be 1 in every state except IDLE.
REQ-019 abort=1 SHALL force IDLE on the next edge, drop dout_valid and SRAM strobes, and produce no done pulse; if abort and start occur together in IDLE, abort wins.
REQ-020 SHALL issue done in FIN one cycle after the last handshake, or one cycle after start when word_cnt==0.

Reset
REQ-021 When nRESET=0, SHALL asynchronously set state=IDLE, SRAM_nCS=SRAM_nOE=SRAM_nWE=1, SRAM_ADDR=0, dout=0, dout_valid=0, busy=0, done=0, and clear all counters.
REQ-022 Reset during a burst SHALL discard the burst; no done pulse SHALL follow reset release.

Configuration
REQ-023 With SRAM_RD_CHKSUM_EN defined, SHALL add output chksum[15:0]: cleared on accepted start, accumulating each handshaken dout modulo 2^16, valid when done=1.
REQ-024 Without SRAM_RD_CHKSUM_EN, the chksum port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 A shared package SHALL hold the state enumeration, the SRAM address width constant, and the default RD_WAIT.
REQ-026 The output register and hold logic SHALL be a sub-module sram_rd_obuf; the FSM and counters SHALL reside in sram_rd_ctrl.

Verification
REQ-027 base_addr=0x00010, word_cnt=4, dout_ready=1, SRAM model returns addr^0xA5A5 -> 4 words 0xA5B5, 0xA5B4, 0xA5B7, 0xA5B6, first valid at cycle 5, then done.
REQ-028 word_cnt=0 -> done pulse 1 cycle after start; SRAM_nCS stays 1.
REQ-029 base_addr=0x3FFFE, word_cnt=3 -> SRAM_ADDR sequence 0x3FFFE, 0x3FFFF, 0x00000.
REQ-030 dout_ready held 0 for 10 cycles on word 2 -> dout stable, no further SRAM access until the handshake.
REQ-031 abort asserted in WAIT of word 2, and separately nRESET pulsed mid-burst -> IDLE, strobes 1, dout_valid 0, no done.
REQ-032 With SRAM_RD_CHKSUM_EN, data 0xFFFF, 0x0002 -> chksum=0x0001 at done.
